// File: rtl/wb_macro_splitter.sv
// Wishbone classic router: one host slave port fanned out to NUM_MACROS
// macro slave ports, one transaction in flight, with decode-miss and
// timeout error responses.
module wb_macro_splitter #(
    parameter int unsigned NUM_MACROS = 4,
    parameter int unsigned SEL_LSB    = 16,
    parameter int unsigned SEL_BITS   = 2,
    parameter int unsigned TIMEOUT    = 255,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    output logic [NUM_MACROS-1:0]    m_cyc_o,
    output logic [NUM_MACROS-1:0]    m_stb_o,
    output logic                     m_we_o,
    output logic [3:0]               m_sel_o,
    output logic [31:0]              m_adr_o,
    output logic [31:0]              m_dat_o,
    input  logic [NUM_MACROS-1:0]    m_ack_i,
    input  logic [32*NUM_MACROS-1:0] m_dat_i,
    output logic                     timeout_o,
    output logic [7:0]               err_cnt_o,
    output logic [3:0]               last_idx_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [3:0]            idx_q, idx_d;
    logic [NUM_MACROS-1:0] strb_q, strb_d;
    logic                  we_q, we_d;
    logic [3:0]            sel_q, sel_d;
    logic [31:0]           adr_q, adr_d;
    logic [31:0]           mdat_q, mdat_d;
    logic [31:0]           rdat_q, rdat_d;
    logic                  tout_q, tout_d;
    logic [7:0]            err_q, err_d;

    logic [3:0]            req_idx;
    logic                  req_hit;
    logic                  ack_sel;
    logic [31:0]           dat_sel;

    // Macro index of the incoming host address and whether a port exists for it
    always_comb begin
        req_idx = 4'(wbs_adr_i[SEL_LSB +: SEL_BITS]);
        req_hit = 32'(req_idx) < NUM_MACROS;
    end

    // Select ack and read data of the macro currently addressed
    always_comb begin
        ack_sel = 1'b0;
        dat_sel = '0;
        for (int unsigned k = 0; k < NUM_MACROS; k++) begin
            if (idx_q == 4'(k)) begin
                ack_sel = m_ack_i[k];
                dat_sel = m_dat_i[32*k +: 32];
            end
        end
    end

    // Transaction FSM: accept in IDLE, wait for ack/timeout/abort in REQ, ack host in RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        strb_d  = strb_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        mdat_d  = mdat_q;
        rdat_d  = rdat_q;
        tout_d  = tout_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    adr_d  = wbs_adr_i;
                    mdat_d = wbs_dat_i;
                    we_d   = wbs_we_i;
                    sel_d  = wbs_sel_i;
                    idx_d  = req_idx;
                    if (req_hit) begin
                        for (int unsigned k = 0; k < NUM_MACROS; k++) begin
                            strb_d[k] = (req_idx == 4'(k));
                        end
                        cnt_d   = '0;
                        state_d = ST_REQ;
                    end else begin
                        rdat_d  = ERR_DATA;
                        err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_REQ: begin
                // host abort wins over a coincident macro ack or timeout
                if (!wbs_cyc_i) begin
                    strb_d  = '0;
                    state_d = ST_IDLE;
                end else if (ack_sel) begin
                    rdat_d  = dat_sel;
                    strb_d  = '0;
                    state_d = ST_RESP;
                end else if (cnt_q == 8'(TIMEOUT)) begin
                    strb_d  = '0;
                    rdat_d  = ERR_DATA;
                    tout_d  = 1'b1;
                    err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            strb_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            mdat_q  <= '0;
            rdat_q  <= '0;
            tout_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            strb_q  <= strb_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            mdat_q  <= mdat_d;
            rdat_q  <= rdat_d;
            tout_q  <= tout_d;
            err_q   <= err_d;
        end
    end

    assign wbs_ack_o  = (state_q == ST_RESP);
    assign wbs_dat_o  = rdat_q;
    assign m_cyc_o    = strb_q;
    assign m_stb_o    = strb_q;
    assign m_we_o     = we_q;
    assign m_sel_o    = sel_q;
    assign m_adr_o    = adr_q;
    assign m_dat_o    = mdat_q;
    assign timeout_o  = tout_q;
    assign err_cnt_o  = err_q;
    assign last_idx_o = idx_q;

endmodule

// File: tb/tb_wb_macro_splitter.sv
// Self-checking bench for wb_macro_splitter: directed scenarios plus a
// randomized run checked against a transaction-level outcome model.
module tb_wb_macro_splitter;

    localparam int unsigned NM   = 4;
    localparam int unsigned SLSB = 16;
    localparam int unsigned SB   = 3;
    localparam int unsigned TO   = 5;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
    logic [3:0]  sel_i = '0;
    logic [31:0] adr_i = '0, dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [NM-1:0] m_cyc_o, m_stb_o;
    logic        m_we_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_adr_o, m_dat_o;
    logic [NM-1:0] ack_r = '0;
    logic [32*NM-1:0] m_dat;
    logic [31:0] mac_dat [NM];
    logic        timeout_o;
    logic [7:0]  err_cnt_o;
    logic [3:0]  last_idx_o;

    int checks = 0;
    int errors = 0;
    int exp_err = 0;
    logic exp_tout = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        m_dat = '0;
        for (int k = 0; k < int'(NM); k++) m_dat[32*k +: 32] = mac_dat[k];
    end

    wb_macro_splitter #(
        .NUM_MACROS(NM), .SEL_LSB(SLSB), .SEL_BITS(SB), .TIMEOUT(TO), .ERR_DATA(ERRD)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc_i), .wbs_stb_i(stb_i), .wbs_we_i(we_i), .wbs_sel_i(sel_i),
        .wbs_adr_i(adr_i), .wbs_dat_i(dat_i), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_ack_i(ack_r), .m_dat_i(m_dat),
        .timeout_o(timeout_o), .err_cnt_o(err_cnt_o), .last_idx_o(last_idx_o)
    );

    // Host driver plus behavioural macros. d = REQ cycles the target macro
    // waits before acking (negative: never). Returns the edge count at which
    // the host sees ack, data, strobes seen, strobe-high cycles and flags.
    task automatic run_txn(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, input int d, input bit noise,
                           output int lat, output logic [31:0] rd, output logic [NM-1:0] seen,
                           output int stb_cyc, output bit bad_stb, output bit ack_long);
        int tgt;
        tgt = int'(adr[SLSB +: SB]);
        lat = -1; rd = '0; seen = '0; stb_cyc = 0; bad_stb = 0; ack_long = 0;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
        ack_r = noise ? NM'($urandom) : '0;
        if (tgt < int'(NM)) ack_r[tgt] = 1'b0;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(posedge clk); #1;
            if (m_stb_o !== m_cyc_o) bad_stb = 1;
            if ($countones(m_stb_o) > 1) bad_stb = 1;
            seen |= m_stb_o;
            if (m_stb_o != '0) stb_cyc++;
            if (wbs_ack_o === 1'b1) begin
                lat = n;
                rd = wbs_dat_o;
            end else begin
                ack_r = noise ? NM'($urandom) : '0;
                if (tgt < int'(NM)) ack_r[tgt] = (d >= 0) && (n - 1 >= d);
            end
        end
        if (lat >= 0) begin
            @(posedge clk); #1;
            if (wbs_ack_o !== 1'b0) ack_long = 1;
        end
        cyc_i = 1'b0; stb_i = 1'b0;
        ack_r = noise ? NM'($urandom) : '0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({wbs_ack_o, wbs_dat_o} !== '0) begin errors++; $display("FAIL reset_host: got ack=%b dat=%h exp 0", wbs_ack_o, wbs_dat_o); end
        checks++; if ({m_cyc_o, m_stb_o} !== '0) begin errors++; $display("FAIL reset_strobe: got cyc=%b stb=%b exp 0", m_cyc_o, m_stb_o); end
        checks++; if ({m_we_o, m_sel_o, m_adr_o, m_dat_o} !== '0) begin errors++; $display("FAIL reset_mbus: got we=%b sel=%h adr=%h dat=%h exp 0", m_we_o, m_sel_o, m_adr_o, m_dat_o); end
        checks++; if ({timeout_o, err_cnt_o, last_idx_o} !== '0) begin errors++; $display("FAIL reset_status: got tout=%b err=%0d last=%0d exp 0", timeout_o, err_cnt_o, last_idx_o); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read();
        int lat, sc; logic [31:0] rd; logic [NM-1:0] seen; bit bad, al;
        for (int k = 0; k < int'(NM); k++) mac_dat[k] = 32'd1 << k;
        run_txn(32'h0002_0000, 1'b0, 32'h1234_5678, 4'hF, 0, 0, lat, rd, seen, sc, bad, al);
        checks++; if (lat != 2) begin errors++; $display("FAIL read_lat: got %0d exp 2", lat); end
        checks++; if (rd !== 32'd4) begin errors++; $display("FAIL read_data: got %h exp 00000004", rd); end
        checks++; if (seen !== 4'b0100 || sc != 1) begin errors++; $display("FAIL read_strobe: got seen=%b cycles=%0d exp 0100/1", seen, sc); end
        checks++; if (bad || al) begin errors++; $display("FAIL read_shape: got bad=%0d ack_long=%0d exp 0/0", bad, al); end
        checks++; if (last_idx_o !== 4'd2 || wbs_dat_o !== 32'd4) begin errors++; $display("FAIL read_hold: got last=%0d dat=%h exp 2/4", last_idx_o, wbs_dat_o); end
    endtask

    task automatic test_timeout();
        int lat, sc; logic [31:0] rd; logic [NM-1:0] seen; bit bad, al;
        run_txn(32'h0001_0040, 1'b1, 32'hCAFE_0001, 4'h3, -1, 0, lat, rd, seen, sc, bad, al);
        exp_err++; exp_tout = 1'b1;
        checks++; if (lat != int'(TO) + 2) begin errors++; $display("FAIL tout_lat: got %0d exp %0d", lat, TO + 2); end
        checks++; if (rd !== ERRD) begin errors++; $display("FAIL tout_data: got %h exp %h", rd, ERRD); end
        checks++; if (seen !== 4'b0010 || sc != int'(TO) + 1) begin errors++; $display("FAIL tout_strobe: got seen=%b cycles=%0d exp 0010/%0d", seen, sc, TO + 1); end
        checks++; if (timeout_o !== 1'b1 || int'(err_cnt_o) != exp_err) begin errors++; $display("FAIL tout_status: got tout=%b err=%0d exp 1/%0d", timeout_o, err_cnt_o, exp_err); end
        checks++; if (m_we_o !== 1'b1 || m_sel_o !== 4'h3 || m_dat_o !== 32'hCAFE_0001) begin errors++; $display("FAIL tout_mbus: got we=%b sel=%h dat=%h exp 1/3/cafe0001", m_we_o, m_sel_o, m_dat_o); end
    endtask

    task automatic test_decode_miss();
        int lat, sc; logic [31:0] rd; logic [NM-1:0] seen; bit bad, al;
        run_txn(32'h0004_0010, 1'b1, 32'h0BAD_0BAD, 4'h1, 0, 1, lat, rd, seen, sc, bad, al);
        exp_err++;
        checks++; if (lat != 1 || rd !== ERRD) begin errors++; $display("FAIL miss_resp: got lat=%0d dat=%h exp 1/%h", lat, rd, ERRD); end
        checks++; if (seen !== '0 || sc != 0) begin errors++; $display("FAIL miss_strobe: got seen=%b cycles=%0d exp 0/0", seen, sc); end
        checks++; if (int'(err_cnt_o) != exp_err || last_idx_o !== 4'd4) begin errors++; $display("FAIL miss_status: got err=%0d last=%0d exp %0d/4", err_cnt_o, last_idx_o, exp_err); end
        checks++; if (m_adr_o !== 32'h0004_0010 || al) begin errors++; $display("FAIL miss_adr: got adr=%h ack_long=%0d exp 00040010/0", m_adr_o, al); end
    endtask

    task automatic test_back_to_back();
        int lat0, lat1, sc0, sc1; logic [31:0] rd0, rd1; logic [NM-1:0] s0, s1; bit b0, b1, a0, a1;
        run_txn(32'h0000_0100, 1'b0, 32'h0, 4'hF, 0, 0, lat0, rd0, s0, sc0, b0, a0);
        run_txn(32'h0003_0200, 1'b0, 32'h0, 4'hF, 0, 0, lat1, rd1, s1, sc1, b1, a1);
        checks++; if (lat0 != 2 || rd0 !== 32'd1) begin errors++; $display("FAIL b2b_first: got lat=%0d dat=%h exp 2/1", lat0, rd0); end
        checks++; if (lat1 != 2 || rd1 !== 32'd8) begin errors++; $display("FAIL b2b_second: got lat=%0d dat=%h exp 2/8", lat1, rd1); end
        checks++; if (s0 !== 4'b0001 || s1 !== 4'b1000) begin errors++; $display("FAIL b2b_strobes: got %b then %b exp 0001 then 1000", s0, s1); end
        checks++; if (b0 || b1 || a0 || a1) begin errors++; $display("FAIL b2b_shape: got bad=%0d%0d ack_long=%0d%0d exp 0", b0, b1, a0, a1); end
    endtask

    task automatic test_abort();
        int acks = 0;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h0000_0020; sel_i = 4'hF; ack_r = '0;
        @(posedge clk); #1;
        checks++; if (m_stb_o !== 4'b0001) begin errors++; $display("FAIL abort_strobe: got %b exp 0001", m_stb_o); end
        @(posedge clk); #1;
        cyc_i = 1'b0; stb_i = 1'b0; ack_r = 4'b0001;
        @(posedge clk); #1;
        ack_r = '0;
        checks++; if (m_stb_o !== '0 || m_cyc_o !== '0) begin errors++; $display("FAIL abort_clear: got cyc=%b stb=%b exp 0", m_cyc_o, m_stb_o); end
        if (wbs_ack_o === 1'b1) acks++;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o === 1'b1) acks++;
        end
        checks++; if (acks != 0) begin errors++; $display("FAIL abort_ack: got %0d acks exp 0", acks); end
        checks++; if (int'(err_cnt_o) != exp_err || timeout_o !== exp_tout) begin errors++; $display("FAIL abort_status: got err=%0d tout=%b exp %0d/%b", err_cnt_o, timeout_o, exp_err, exp_tout); end
    endtask

    task automatic test_random();
        int lat, sc, idx, d, el, esc; logic [31:0] rd, adr, dat, ed; logic [NM-1:0] seen, es;
        logic we; logic [3:0] sel; bit bad, al;
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < int'(NM); k++) mac_dat[k] = $urandom;
            idx = int'($urandom_range(0, 7));
            d = int'($urandom_range(0, 7));
            adr = $urandom; adr[SLSB +: SB] = 3'(idx);
            dat = $urandom; we = 1'($urandom); sel = 4'($urandom);
            // Outcome model: miss, macro response, or timeout
            if (idx >= int'(NM)) begin
                el = 1; ed = ERRD; es = '0; esc = 0; exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
            end else if (d <= int'(TO)) begin
                el = d + 2; ed = mac_dat[idx]; es = NM'(1) << idx; esc = d + 1;
            end else begin
                el = int'(TO) + 2; ed = ERRD; es = NM'(1) << idx; esc = int'(TO) + 1;
                exp_err = (exp_err >= 255) ? 255 : exp_err + 1; exp_tout = 1'b1;
            end
            run_txn(adr, we, dat, sel, d, 1, lat, rd, seen, sc, bad, al);
            checks++; if (lat != el || rd !== ed) begin errors++; $display("FAIL rnd%0d_resp: got lat=%0d dat=%h exp %0d/%h", i, lat, rd, el, ed); end
            checks++; if (seen !== es || sc != esc || bad || al) begin errors++; $display("FAIL rnd%0d_strobe: got seen=%b cyc=%0d bad=%0d al=%0d exp %b/%0d/0/0", i, seen, sc, bad, al, es, esc); end
            checks++; if (m_adr_o !== adr || m_dat_o !== dat || m_we_o !== we || m_sel_o !== sel) begin errors++; $display("FAIL rnd%0d_mbus: got %h %h %b %h exp %h %h %b %h", i, m_adr_o, m_dat_o, m_we_o, m_sel_o, adr, dat, we, sel); end
            checks++; if (int'(err_cnt_o) != exp_err || timeout_o !== exp_tout || int'(last_idx_o) != idx) begin errors++; $display("FAIL rnd%0d_status: got err=%0d tout=%b last=%0d exp %0d/%b/%0d", i, err_cnt_o, timeout_o, last_idx_o, exp_err, exp_tout, idx); end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                ack_r = NM'($urandom);
            end
        end
    endtask

    task automatic test_err_saturate();
        int lat, sc; logic [31:0] rd; logic [NM-1:0] seen; bit bad, al;
        for (int i = 0; i < 260; i++) begin
            run_txn(32'h0007_0000, 1'b0, 32'h0, 4'hF, 0, 0, lat, rd, seen, sc, bad, al);
            exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
        end
        checks++; if (int'(err_cnt_o) != exp_err || err_cnt_o !== 8'd255) begin errors++; $display("FAIL err_saturate: got %0d exp 255", err_cnt_o); end
    endtask

    task automatic test_reset_mid_req();
        int lat, sc, acks = 0; logic [31:0] rd; logic [NM-1:0] seen; bit bad, al;
        cyc_i = 1'b1; stb_i = 1'b1; adr_i = 32'h0002_0000; ack_r = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #3 rst_n = 1'b0;
        #1;
        checks++; if (m_stb_o !== '0 || m_cyc_o !== '0 || wbs_ack_o !== 1'b0) begin errors++; $display("FAIL rstmid_bus: got stb=%b cyc=%b ack=%b exp 0", m_stb_o, m_cyc_o, wbs_ack_o); end
        checks++; if (timeout_o !== 1'b0 || err_cnt_o !== 8'd0 || wbs_dat_o !== '0 || last_idx_o !== '0) begin errors++; $display("FAIL rstmid_status: got tout=%b err=%0d dat=%h last=%0d exp 0", timeout_o, err_cnt_o, wbs_dat_o, last_idx_o); end
        cyc_i = 1'b0; stb_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_err = 0; exp_tout = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (wbs_ack_o === 1'b1) acks++;
        end
        checks++; if (acks != 0) begin errors++; $display("FAIL rstmid_noack: got %0d acks exp 0", acks); end
        run_txn(32'h0003_0000, 1'b0, 32'h0, 4'hF, 2, 1, lat, rd, seen, sc, bad, al);
        checks++; if (lat != 4 || rd !== mac_dat[3] || seen !== 4'b1000) begin errors++; $display("FAIL rstmid_after: got lat=%0d dat=%h seen=%b exp 4/%h/1000", lat, rd, seen, mac_dat[3]); end
        checks++; if (err_cnt_o !== 8'd0 || timeout_o !== 1'b0) begin errors++; $display("FAIL rstmid_after_status: got err=%0d tout=%b exp 0/0", err_cnt_o, timeout_o); end
    endtask

    initial begin
        for (int k = 0; k < int'(NM); k++) mac_dat[k] = '0;
        test_reset();
        test_read();
        test_timeout();
        test_decode_miss();
        test_back_to_back();
        test_abort();
        test_random();
        test_err_saturate();
        test_reset_mid_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
